// File: rtl/pueo_trig_pkg.sv
// Shared constants and types for the TURF trigger scheduler.
package pueo_trig_pkg;

  localparam int unsigned SRC_SOFT        = 0;
  localparam int unsigned SRC_PPS         = 1;
  localparam int unsigned SRC_EXT         = 2;

  localparam int unsigned TRIG_META_BITS  = 8;
  localparam int unsigned DROP_CNT_BITS   = 16;
  localparam int unsigned HOLDOFF_BITS    = 16;
  localparam int unsigned ISSUED_CNT_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } turf_sched_state_t;

  typedef logic [TRIG_META_BITS-1:0] trig_meta_t;

endpackage

// File: rtl/pueo_trig_req_latch.sv
// Per-source request latch: pending flag, time-stamped address, metadata and drop counter.
module pueo_trig_req_latch
  import pueo_trig_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                     sysclk_i,
  input  logic                     rst_n_i,
  input  logic                     running_i,
  input  logic                     req_i,
  input  logic                     clr_i,
  input  logic [ADDR_BITS-1:0]     cur_addr_i,
  input  logic [ADDR_BITS-1:0]     offset_i,
  input  trig_meta_t               meta_i,
  output logic                     pending_o,
  output logic [ADDR_BITS-1:0]     addr_o,
  output trig_meta_t               meta_o,
  output logic [DROP_CNT_BITS-1:0] drop_count_o
);

  logic capture;
  logic drop;

  // A grant clearing this source in the same cycle frees the slot for the new request.
  assign capture = running_i & req_i & (~pending_o | clr_i);
  assign drop    = running_i & req_i & pending_o & ~clr_i;

  // Pending flag: set on capture, cleared by grant or by leaving run.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_o <= 1'b0;
    end else if (!running_i) begin
      pending_o <= 1'b0;
    end else if (capture) begin
      pending_o <= 1'b1;
    end else if (clr_i) begin
      pending_o <= 1'b0;
    end
  end

  // Address and metadata of the first accepted request.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_o <= '0;
      meta_o <= '0;
    end else if (capture) begin
      addr_o <= ADDR_BITS'(cur_addr_i - offset_i);
      meta_o <= meta_i;
    end
  end

  // Saturating count of requests lost while already pending.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_count_o <= '0;
    end else if (drop && (drop_count_o != {DROP_CNT_BITS{1'b1}})) begin
      drop_count_o <= drop_count_o + DROP_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/pueo_turf_trig_sched.sv
// Schedules soft/PPS/ext triggers onto the TURF trigger slot with priority and holdoff.
module pueo_turf_trig_sched
  import pueo_trig_pkg::*;
#(
  parameter int unsigned NSRC      = 3,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                             sysclk_i,
  input  logic                             rst_n_i,
  input  logic                             running_i,
  input  logic [ADDR_BITS-1:0]             cur_addr_i,
  input  logic                             trig_slot_i,
  input  logic [NSRC-1:0]                  req_i,
  input  logic [NSRC*TRIG_META_BITS-1:0]   req_meta_i,
  input  logic [NSRC*ADDR_BITS-1:0]        req_offset_i,
  input  logic [HOLDOFF_BITS-1:0]          holdoff_i,
  output logic [ADDR_BITS-1:0]             turf_trig_o,
  output logic [TRIG_META_BITS-1:0]        turf_metadata_o,
  output logic                             turf_valid_o,
  output logic [NSRC-1:0]                  pending_o,
  output logic [NSRC*DROP_CNT_BITS-1:0]    drop_count_o,
  output logic [ISSUED_CNT_BITS-1:0]       issued_count_o
);

  localparam int unsigned SEL_BITS = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [ADDR_BITS-1:0]    src_addr [NSRC];
  trig_meta_t              src_meta [NSRC];
  logic [NSRC-1:0]         clr;
  logic                    any_pend;
  logic [SEL_BITS-1:0]     win;

  turf_sched_state_t       state_q, state_d;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic                    load;
  logic                    issue;
  logic [ADDR_BITS-1:0]    gnt_addr_q;
  trig_meta_t              gnt_meta_q;

  // One request latch per source.
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    pueo_trig_req_latch #(
      .ADDR_BITS (ADDR_BITS)
    ) u_latch (
      .sysclk_i     (sysclk_i),
      .rst_n_i      (rst_n_i),
      .running_i    (running_i),
      .req_i        (req_i[s]),
      .clr_i        (clr[s]),
      .cur_addr_i   (cur_addr_i),
      .offset_i     (req_offset_i[s*ADDR_BITS +: ADDR_BITS]),
      .meta_i       (req_meta_i[s*TRIG_META_BITS +: TRIG_META_BITS]),
      .pending_o    (pending_o[s]),
      .addr_o       (src_addr[s]),
      .meta_o       (src_meta[s]),
      .drop_count_o (drop_count_o[s*DROP_CNT_BITS +: DROP_CNT_BITS])
    );
  end

  // Fixed priority: highest pending index wins.
  always_comb begin
    any_pend = 1'b0;
    win      = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending_o[i]) begin
        any_pend = 1'b1;
        win      = SEL_BITS'(i);
      end
    end
  end

  // State and holdoff counter registers.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: grant in IDLE, issue on slot in ARMED, count down in HOLDOFF.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    clr     = '0;
    load    = 1'b0;
    issue   = 1'b0;
    if (!running_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pend) begin
            clr[win] = 1'b1;
            load     = 1'b1;
            state_d  = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_slot_i) begin
            issue   = 1'b1;
            hold_d  = holdoff_i;
            state_d = (holdoff_i == '0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_q - HOLDOFF_BITS'(1);
          if (hold_q <= HOLDOFF_BITS'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Granted payload waiting for its slot.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gnt_addr_q <= '0;
      gnt_meta_q <= '0;
    end else if (load) begin
      gnt_addr_q <= src_addr[win];
      gnt_meta_q <= src_meta[win];
    end
  end

  // Output stage and issued-trigger counter.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      turf_valid_o    <= 1'b0;
      turf_trig_o     <= '0;
      turf_metadata_o <= '0;
      issued_count_o  <= '0;
    end else begin
      turf_valid_o <= issue;
      if (issue) begin
        turf_trig_o     <= gnt_addr_q;
        turf_metadata_o <= gnt_meta_q;
        issued_count_o  <= issued_count_o + ISSUED_CNT_BITS'(1);
      end
    end
  end

endmodule
